// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// shift-add multiplier, with a valid/ready handshake on both sides.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [7:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rout,
  output logic [WIDTH-1:0] rout_hi,
  output logic [7:0]       flag
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned CW  = $clog2(WIDTH) + 1;

  localparam int unsigned FC = 0;
  localparam int unsigned FL = 2;
  localparam int unsigned FF = 5;
  localparam int unsigned FZ = 6;
  localparam int unsigned FN = 7;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_MULT = 8'h0E;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   rout_q, rout_d;
  logic [WIDTH-1:0]   rout_hi_q, rout_hi_d;
  logic [7:0]         flag_q, flag_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic               cin;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [SHW-1:0]     shamt;
  logic               shift_oor;
  logic [WIDTH-1:0]   alu_res;
  logic [7:0]         alu_flag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;

  assign in_ready  = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign rout      = rout_q;
  assign rout_hi   = rout_hi_q;
  assign flag      = flag_q;

  // Carry-in is the registered C, so a chained ADDC/SUBC sees the previous op's carry.
  assign cin       = ((opcode == OP_ADDC) || (opcode == OP_SUBC)) ? flag_q[FC] : 1'b0;
  assign add_sum   = {1'b0, r1} + {1'b0, r2} + W1'(cin);
  assign sub_diff  = {1'b0, r1} - {1'b0, r2} - W1'(cin);
  assign shamt     = r1[SHW-1:0];
  assign shift_oor = |r1[WIDTH-1:SHW];

  // One shift-add step: conditionally add multiplicand into the upper half, then shift right.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
  assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};

  // Single-cycle result and flag update
  always_comb begin
    alu_res  = '0;
    alu_flag = flag_q;
    case (opcode)
      OP_ADD, OP_ADDC: begin
        alu_res      = add_sum[WIDTH-1:0];
        alu_flag     = '0;
        alu_flag[FC] = add_sum[WIDTH];
        alu_flag[FF] = (r1[MSB] == r2[MSB]) && (add_sum[MSB] != r1[MSB]);
      end
      OP_ADDU: alu_res = add_sum[WIDTH-1:0];
      OP_SUB, OP_SUBC: begin
        alu_res      = sub_diff[WIDTH-1:0];
        alu_flag     = '0;
        alu_flag[FC] = sub_diff[WIDTH];
        alu_flag[FF] = (r1[MSB] != r2[MSB]) && (sub_diff[MSB] != r1[MSB]);
      end
      OP_CMP: begin
        alu_res      = sub_diff[WIDTH-1:0];
        alu_flag     = '0;
        alu_flag[FZ] = (r1 == r2);
        alu_flag[FL] = sub_diff[WIDTH];
        alu_flag[FN] = ($signed(r1) < $signed(r2));
      end
      OP_AND:         alu_res = r1 & r2;
      OP_OR:          alu_res = r1 | r2;
      OP_XOR:         alu_res = r1 ^ r2;
      OP_NOT:         alu_res = ~r1;
      OP_LSH, OP_ALSH: alu_res = shift_oor ? '0 : (r2 << shamt);
      OP_RSH:         alu_res = shift_oor ? '0 : (r2 >> shamt);
      OP_ARSH:        alu_res = shift_oor ? {WIDTH{r2[MSB]}}
                                          : WIDTH'($signed(r2) >>> shamt);
      default: begin
        alu_res  = '0;
        alu_flag = flag_q;
      end
    endcase
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    rout_d      = rout_q;
    rout_hi_d   = rout_hi_q;
    flag_d      = flag_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (opcode == OP_MULT) begin
            state_d = S_MUL;
            prod_d  = {{WIDTH{1'b0}}, r1};
            mcand_d = r2;
            cnt_d   = '0;
          end else begin
            out_valid_d = 1'b1;
            rout_d      = alu_res;
            rout_hi_d   = '0;
            flag_d      = alu_flag;
          end
        end
      end
      S_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          rout_d      = prod_step[WIDTH-1:0];
          rout_hi_d   = prod_step[2*WIDTH-1:WIDTH];
          flag_d      = '0;
          flag_d[FZ]  = (prod_step == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      rout_q      <= '0;
      rout_hi_q   <= '0;
      flag_q      <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rout_q      <= rout_d;
      rout_hi_q   <= rout_hi_d;
      flag_q      <= flag_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; legal values 8, 16, 32.
REQ-002 Parameter SHW, default $clog2(WIDTH): number of shift-amount bits examined for the in-range test.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 r1  input  WIDTH  operand A; also the shift amount for shift ops.
REQ-008 r2  input  WIDTH  operand B; also the value shifted by shift ops.
REQ-009 opcode  input  8  operation select.
REQ-010 out_valid  output  1  rout, rout_hi and flag hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 rout  output  WIDTH  result.
REQ-013 rout_hi  output  WIDTH  upper product half for MULT; 0 for all other ops.
REQ-014 flag  output  8  persistent flags: bit0 C, bit2 L, bit5 F (overflow), bit6 Z, bit7 N; bits 1, 3 and 4 always 0.

Function
REQ-015 Accept condition: in_valid && in_ready.
- in_ready = !reset && state==IDLE && (!out_valid || out_ready).
REQ-016 States:
- IDLE -> MUL on accepting MULT.
- MUL -> IDLE after exactly WIDTH iteration cycles, loading the output registers.
- Every other opcode stays in IDLE.
REQ-017 Single-cycle ops load rout/rout_hi/flag and set out_valid on the edge of acceptance, so latency is 1 cycle.
REQ-018 out_valid clears on out_valid && out_ready unless a new result loads on the same edge.
- rout, rout_hi and flag hold stable while out_valid && !out_ready.
REQ-019 Opcodes, all arithmetic modulo 2^WIDTH:
- ADD 0x05 = r1+r2
- ADDU 0x06 = r1+r2
- ADDC 0x07 = r1+r2+C
- SUB 0x09 = r1-r2
- SUBC 0x0A = r1-r2-C
- CMP 0x0B = r1-r2
- AND 0x01, OR 0x02, XOR 0x03
- NOT 0x04 = ~r1
- LSH 0x84 and ALSH 0x0C = r2<<r1
- RSH 0x08 = r2>>r1 (logical)
- ARSH 0x0F = r2>>>r1 (sign-filling)
- MULT 0x0E = unsigned r1*r2, 2*WIDTH bits.
REQ-020 Shifts with r1 >= WIDTH: LSH, ALSH and RSH yield 0; ARSH yields all copies of r2[WIDTH-1].
REQ-021 ADD/ADDC flag update:
- C = carry out.
- F = signed overflow (operand MSBs equal and result MSB differs).
- L, Z, N cleared.
REQ-022 SUB/SUBC flag update:
- C = borrow (1 when the unsigned true difference is negative).
- F = operand MSBs differ and result MSB differs from r1 MSB.
- L, Z, N cleared.
REQ-023 CMP flag update:
- Z = (r1==r2); L = unsigned r1<r2; N = signed r1<r2.
- C, F cleared.
REQ-024 MULT flag update: Z = (full product == 0); all other flags cleared.
REQ-025 ADDU, logic, shift and NOT ops leave flag unchanged.
REQ-026 ADDC and SUBC use C as registered before the accepting edge, including C written by the immediately preceding op.
REQ-027 Unlisted opcodes: rout=0, rout_hi=0, flag unchanged, out_valid still asserted.
REQ-028 MULT is an iterative shift-add, one multiplier bit per cycle.
- rout = product[WIDTH-1:0]; rout_hi = product[2*WIDTH-1:WIDTH].
- out_valid rises WIDTH+1 cycles after the accepting edge.
REQ-029 Throughput: back-to-back single-cycle ops at 1 per cycle while out_ready is held high.

Reset
REQ-030 reset high at a clock edge sets state=IDLE, out_valid=0, rout=0, rout_hi=0, flag=0 and discards any MULT in progress.
REQ-031 in_ready is 0 while reset is high and 1 on the first cycle after reset deasserts.
REQ-032 Operations presented during reset are not accepted.

Verification (WIDTH=16)
REQ-033 ADD r1=0x7FFF, r2=0x0001 -> next cycle out_valid=1, rout=0x8000, flag=0x20.
REQ-034 ADD 0xFFFF+0x0001 -> rout=0x0000, flag=0x01; then immediately ADDC 0x0001+0x0001 -> rout=0x0003, flag=0x00.
REQ-035 CMP r1=0xFFFF, r2=0x0001 -> flag=0x80; CMP r1=0x0005, r2=0x0005 -> flag=0x40, rout=0x0000.
REQ-036 MULT r1=0x0123, r2=0x0100:
- in_ready=0 for 16 cycles.
- out_valid at cycle 17 after accept.
- rout=0x2300, rout_hi=0x0001, flag=0x00.
REQ-037 Backpressure: ARSH r1=20, r2=0x8000 with out_ready=0 for 5 cycles.
- rout=0xFFFF held throughout; in_ready=0 throughout.
- Accepted on the out_ready=1 cycle.
REQ-038 Reset asserted at cycle 5 of a MULT:
- Next cycle out_valid=0, flag=0x00, no result emitted.
- in_ready=1 once reset drops.
